// File: rtl/roll_controller.sv
// rtl/roll_controller.sv - dice roll sequencer: button sync, LFSR, timed animation, scoring
module roll_controller #(
  parameter int ANIM_DIV   = 2500000,
  parameter int ROLL_STEPS = 12,
  parameter int TARGET     = 30,
  parameter int SCORE_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         state,
  input  logic               roll_btn,
  output logic               die_rolled_n,
  output logic [2:0]         die_val,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               has_won,
  output logic [1:0]         winner,
  output logic               busy,
  output logic [15:0]        rand_q
);

  localparam int DIV_W  = $clog2(ANIM_DIV + 1);
  localparam int STEP_W = $clog2(ROLL_STEPS + 1);

  typedef enum logic [2:0] {IDLE, ROLLING, LATCH, ADD, DONE} fsm_t;

  fsm_t              fsm;
  logic              btn_meta;
  logic              btn_sync;
  logic              armed;
  logic              player_p1;
  logic [DIV_W-1:0]  div_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic              press;
  logic              lfsr_fb;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] new_score;
  logic [SCORE_W:0]   sum;

  assign press   = ~btn_sync & armed;
  assign lfsr_fb = rand_q[15] ^ rand_q[13] ^ rand_q[12] ^ rand_q[10];
  assign busy    = (fsm != IDLE);

  // Saturating add for whichever player was captured at press time
  always_comb begin
    cur_score = player_p1 ? p1_score : p2_score;
    sum       = {1'b0, cur_score} + (SCORE_W+1)'(die_val);
    new_score = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta     <= 1'b1;
      btn_sync     <= 1'b1;
      armed        <= 1'b1;
      rand_q       <= 16'hACE1;
      fsm          <= IDLE;
      player_p1    <= 1'b0;
      div_cnt      <= '0;
      step_cnt     <= '0;
      die_rolled_n <= 1'b1;
      die_val      <= 3'd1;
      p1_score     <= '0;
      p2_score     <= '0;
      has_won      <= 1'b0;
      winner       <= 2'b00;
    end else begin
      btn_meta     <= roll_btn;
      btn_sync     <= btn_meta;
      rand_q       <= {rand_q[14:0], lfsr_fb};
      // A press disarms until the button is seen released again
      armed        <= btn_sync;
      die_rolled_n <= 1'b1;
      if (state == 2'b00) begin
        fsm      <= IDLE;
        p1_score <= '0;
        p2_score <= '0;
        has_won  <= 1'b0;
        winner   <= 2'b00;
        die_val  <= 3'd1;
      end else begin
        case (fsm)
          IDLE: begin
            if (press && (state == 2'b01 || state == 2'b10)) begin
              player_p1 <= state[0];
              div_cnt   <= '0;
              step_cnt  <= '0;
              die_val   <= 3'd1;
              fsm       <= ROLLING;
            end
          end
          ROLLING: begin
            if (div_cnt == DIV_W'(ANIM_DIV - 1)) begin
              div_cnt  <= '0;
              step_cnt <= step_cnt + 1'b1;
              if (step_cnt == STEP_W'(ROLL_STEPS - 1)) begin
                fsm <= LATCH;
              end else begin
                die_val <= (die_val == 3'd6) ? 3'd1 : die_val + 3'd1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          LATCH: begin
            die_val <= 3'(rand_q[7:0] % 8'd6) + 3'd1;
            fsm     <= ADD;
          end
          ADD: begin
            if (player_p1) p1_score <= new_score;
            else           p2_score <= new_score;
            if (32'(new_score) >= 32'(TARGET)) begin
              has_won <= 1'b1;
              winner  <= player_p1 ? 2'b01 : 2'b10;
            end
            die_rolled_n <= 1'b0;
            fsm          <= DONE;
          end
          DONE:    fsm <= IDLE;
          default: fsm <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_roll_controller.sv
// tb/tb_roll_controller.sv - directed, table-driven bench for roll_controller
module tb_roll_controller;

  localparam int TG = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  state = 2'b00;
  logic [1:0]  state2 = 2'b00;
  logic        roll_btn = 1'b1;
  logic        roll_btn2 = 1'b1;

  logic        drn, hw, busy;
  logic [2:0]  dv;
  logic [5:0]  p1, p2;
  logic [1:0]  win;
  logic [15:0] rq;

  logic        drn2, hw2, busy2;
  logic [2:0]  dv2;
  logic [2:0]  p1b, p2b;
  logic [1:0]  win2;
  logic [15:0] rq2;

  roll_controller #(.ANIM_DIV(2), .ROLL_STEPS(3), .TARGET(TG), .SCORE_W(6)) dut (
    .clk(clk), .reset(reset), .state(state), .roll_btn(roll_btn),
    .die_rolled_n(drn), .die_val(dv), .p1_score(p1), .p2_score(p2),
    .has_won(hw), .winner(win), .busy(busy), .rand_q(rq)
  );

  roll_controller #(.ANIM_DIV(2), .ROLL_STEPS(3), .TARGET(TG), .SCORE_W(3)) dut_sat (
    .clk(clk), .reset(reset), .state(state2), .roll_btn(roll_btn2),
    .die_rolled_n(drn2), .die_val(dv2), .p1_score(p1b), .p2_score(p2b),
    .has_won(hw2), .winner(win2), .busy(busy2), .rand_q(rq2)
  );

  always #5 clk = ~clk;

  logic [15:0] m_lfsr;
  always @(posedge clk)
    m_lfsr <= reset ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  typedef struct {
    logic [1:0] st;
    int         hold;
    logic       exp_roll;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int rise_cyc = 0;
  int bidx = 0;
  int mp1 = 0, mp2 = 0, mwin = 0, m2p1 = 0;
  logic mwon = 1'b0;
  logic cur_p1 = 1'b0;
  logic busy_prev = 1'b0;
  logic busy_seen = 1'b0;
  logic [15:0] h0, h1, h2;
  logic [2:0] trace [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] face;
    int ns;
    @(negedge clk);
    cyc++;
    h2 = h1; h1 = h0; h0 = m_lfsr;
    if (busy === 1'b1) begin
      if (!busy_prev) begin rise_cyc = cyc; bidx = 0; end
      if (bidx < 16) trace[bidx] = dv;
      bidx++;
      busy_seen = 1'b1;
    end
    busy_prev = (busy === 1'b1);
    // LATCH happened two cycles before the pulse cycle
    if (drn === 1'b0) begin
      pulses++;
      pulse_cyc = cyc;
      face = 3'(h2[7:0] % 6) + 3'd1;
      chk("die_face", 32'(dv), 32'(face));
      ns = (cur_p1 ? mp1 : mp2) + int'(face);
      if (ns > 63) ns = 63;
      if (cur_p1) mp1 = ns; else mp2 = ns;
      if (ns >= TG) begin mwon = 1'b1; mwin = cur_p1 ? 1 : 2; end
    end
    if (drn2 === 1'b0) begin
      face = 3'(h2[7:0] % 6) + 3'd1;
      chk("sat_face", 32'(dv2), 32'(face));
      ns = m2p1 + int'(face);
      if (ns > 7) ns = 7;
      m2p1 = ns;
    end
  endtask

  task automatic clear_model();
    mp1 = 0; mp2 = 0; mwon = 1'b0; mwin = 0;
  endtask

  task automatic roll(input logic [1:0] st, input logic [1:0] mid_st, input int hold,
                      input logic exp_roll);
    int p0;
    p0 = pulses;
    busy_seen = 1'b0;
    state = st;
    cur_p1 = st[0];
    roll_btn = 1'b0;
    repeat (hold) tick();
    state = mid_st;
    roll_btn = 1'b1;
    repeat (16) tick();
    if (mid_st == 2'b00) clear_model();
    chk("roll_pulses", 32'(pulses - p0), exp_roll ? 32'd1 : 32'd0);
    chk("roll_busy_seen", 32'(busy_seen), 32'(exp_roll));
    chk("p1_score", 32'(p1), 32'(mp1));
    chk("p2_score", 32'(p2), 32'(mp2));
    chk("has_won", 32'(hw), 32'(mwon));
    chk("winner", 32'(win), 32'(mwin));
  endtask

  initial begin
    vec_t tbl [24];
    int exp_anim [6];
    logic [1:0] eff;
    logic exp_r;
    int p0;

    exp_anim = '{1, 1, 2, 2, 3, 3};
    tbl[0] = '{2'b00, 3, 1'b0};
    tbl[1] = '{2'b11, 3, 1'b0};
    tbl[2] = '{2'b01, 20, 1'b1};
    for (int i = 3; i < 24; i++)
      tbl[i] = '{((i % 2) == 1) ? 2'b10 : 2'b01, 3, 1'b1};

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_rand_q", 32'(rq), 32'h0000ACE1);
    chk("rst_die_rolled_n", 32'(drn), 32'd1);
    chk("rst_die_val", 32'(dv), 32'd1);
    chk("rst_p1", 32'(p1), 32'd0);
    chk("rst_p2", 32'(p2), 32'd0);
    chk("rst_has_won", 32'(hw), 32'd0);
    chk("rst_winner", 32'(win), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("lfsr_step", 32'(rq), 32'h000059C3);

    for (int i = 0; i < 24; i++) begin
      eff = tbl[i].st;
      exp_r = tbl[i].exp_roll;
      if (mwon && (eff == 2'b01 || eff == 2'b10)) begin
        eff = 2'b11;
        exp_r = 1'b0;
      end
      roll(eff, eff, tbl[i].hold, exp_r);
      if (i == 2) begin
        chk("pulse_latency", 32'(pulse_cyc - rise_cyc), 32'd8);
        for (int k = 0; k < 6; k++)
          chk("anim_face", 32'(trace[k]), 32'(exp_anim[k]));
      end
    end
    chk("rand_q_model", 32'(rq), 32'(m_lfsr));
    chk("game_has_won", 32'(hw), 32'd1);

    state = 2'b11;
    repeat (5) tick();
    chk("hold_has_won", 32'(hw), 32'd1);
    chk("hold_winner", 32'(win), 32'(mwin));
    state = 2'b00;
    tick();
    clear_model();
    chk("clr_p1", 32'(p1), 32'd0);
    chk("clr_p2", 32'(p2), 32'd0);
    chk("clr_has_won", 32'(hw), 32'd0);
    chk("clr_winner", 32'(win), 32'd0);

    roll(2'b01, 2'b10, 5, 1'b1);
    chk("captured_player_p2", 32'(p2), 32'd0);

    p0 = pulses;
    state = 2'b01;
    roll_btn = 1'b0;
    repeat (5) tick();
    chk("abort_busy_before", 32'(busy), 32'd1);
    state = 2'b00;
    tick();
    clear_model();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_p1", 32'(p1), 32'd0);
    chk("abort_has_won", 32'(hw), 32'd0);
    chk("abort_die_val", 32'(dv), 32'd1);
    chk("abort_drn", 32'(drn), 32'd1);
    roll_btn = 1'b1;
    repeat (14) tick();
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);

    roll(2'b01, 2'b01, 3, 1'b1);
    p0 = pulses;
    roll_btn = 1'b0;
    repeat (5) tick();
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    roll_btn = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_rand_q", 32'(rq), 32'h0000ACE1);
    chk("rst_mid_p1", 32'(p1), 32'd0);
    chk("rst_mid_die_val", 32'(dv), 32'd1);
    repeat (14) tick();
    chk("rst_mid_no_pulse", 32'(pulses - p0), 32'd0);

    state = 2'b00;
    state2 = 2'b01;
    for (int r = 0; r < 8; r++) begin
      roll_btn2 = 1'b0;
      repeat (3) tick();
      roll_btn2 = 1'b1;
      repeat (16) tick();
      chk("sat_p1_model", 32'(p1b), 32'(m2p1));
    end
    chk("sat_p1_final", 32'(p1b), 32'd7);
    chk("sat_has_won", 32'(hw2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
